// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Each grant pulses transmit, then waits for is_transmitting to rise and fall before re-arbitrating.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int START_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_transmit,
    output logic [7:0]           uart_tx_byte,
    input  logic                 uart_is_transmitting,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [7:0]      TIMER_LAST = 8'(START_TIMEOUT - 1);
    localparam logic [ID_W-1:0] RR_INIT    = ID_W'(NUM_REQ - 1);

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_last_q, rr_last_d;
    logic [7:0]           timer_q, timer_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 uart_transmit_q, uart_transmit_d;
    logic [7:0]           uart_tx_byte_q, uart_tx_byte_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 busy_q, busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 hi_found, lo_found;
    logic [ID_W-1:0]      hi_idx, lo_idx, winner;
    logic [7:0]           win_byte;
    logic [NUM_REQ-1:0]   win_onehot;

    // Winner: lowest valid index above rr_last, otherwise lowest valid index at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (ID_W'(i) > rr_last_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(i);
                end
            end
        end
        winner     = hi_found ? hi_idx : lo_idx;
        win_byte   = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_byte      = req_data[8*i +: 8];
                win_onehot[i] = 1'b1;
            end
        end
    end

    // NOTE: every _d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d         = state_q;
        rr_last_d       = rr_last_q;
        timer_d         = timer_q;
        req_ready_d     = '0;
        uart_transmit_d = 1'b0;
        uart_tx_byte_d  = uart_tx_byte_q;
        grant_id_d      = grant_id_q;
        tx_done_d       = 1'b0;
        timeout_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if ((hi_found || lo_found) && !uart_is_transmitting) begin
                    uart_tx_byte_d  = win_byte;
                    grant_id_d      = winner;
                    rr_last_d       = winner;
                    req_ready_d     = win_onehot;
                    uart_transmit_d = 1'b1;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_is_transmitting) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            rr_last_q       <= RR_INIT;
            timer_q         <= '0;
            req_ready_q     <= '0;
            uart_transmit_q <= 1'b0;
            uart_tx_byte_q  <= '0;
            grant_id_q      <= '0;
            busy_q          <= 1'b0;
            tx_done_q       <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_last_q       <= rr_last_d;
            timer_q         <= timer_d;
            req_ready_q     <= req_ready_d;
            uart_transmit_q <= uart_transmit_d;
            uart_tx_byte_q  <= uart_tx_byte_d;
            grant_id_q      <= grant_id_d;
            busy_q          <= busy_d;
            tx_done_q       <= tx_done_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign uart_transmit = uart_transmit_q;
    assign uart_tx_byte  = uart_tx_byte_q;
    assign grant_id      = grant_id_q;
    assign busy          = busy_q;
    assign tx_done       = tx_done_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART model that holds is_transmitting
// for FRAME cycles after each transmit pulse; outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ       = 4;
    localparam int ID_W          = 2;
    localparam int START_TIMEOUT = 15;
    localparam int FRAME         = 6;
    // transmit seen at negedge N -> is_transmitting low again for the edge after N+6 -> tx_done at N+7
    localparam int DONE_LAT      = FRAME + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_transmit;
    logic [7:0]           uart_tx_byte;
    logic                 is_tx = 1'b0;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 tx_done;
    logic                 timeout_err;

    int n_vectors = 0;
    int n_miscompares = 0;
    int uart_mode = 0;   // 0: normal frame model, 1: never busy, 2: is_tx driven by the stimulus
    int frame_cnt = 0;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
        .uart_is_transmitting(is_tx),
        .grant_id(grant_id), .busy(busy), .tx_done(tx_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (uart_mode == 0) begin
            if (uart_transmit) begin
                is_tx     = 1'b1;
                frame_cnt = FRAME;
            end else if (frame_cnt > 0) begin
                frame_cnt--;
                if (frame_cnt == 0) is_tx = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // which: 0 uart_transmit, 1 tx_done, 2 timeout_err; n = negedges waited, -1 if budget expired
    task automatic wait_for(input int which, input int max, output int n);
        logic hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < max) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = uart_transmit;
                1:       hit = tx_done;
                default: hit = timeout_err;
            endcase
        end
        if (!hit) n = -1;
    endtask

    task automatic expect_grant(input string tag, input int exp_id, input logic [7:0] exp_byte);
        int n;
        wait_for(0, 30, n);
        check({tag, " latency"}, n, 1);
        check({tag, " grant_id"}, 32'(grant_id), exp_id);
        check({tag, " req_ready"}, 32'(req_ready), 32'(1) << exp_id);
        check({tag, " tx_byte"}, 32'(uart_tx_byte), 32'(exp_byte));
    endtask

    task automatic expect_done(input string tag, input int exp_n);
        int n;
        wait_for(1, 40, n);
        check({tag, " done latency"}, n, exp_n);
        check({tag, " busy at done"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] exp_bytes [5];
        int         exp_ids   [5];
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        exp_ids   = '{0, 1, 2, 3, 0};

        // reset values
        repeat (3) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 0);
        check("rst transmit", 32'(uart_transmit), 0);
        check("rst tx_byte", 32'(uart_tx_byte), 0);
        check("rst grant_id", 32'(grant_id), 0);
        check("rst busy/done/tmo", 32'({busy, tx_done, timeout_err}), 0);
        rst = 1'b0;

        // 1: single request from requester 0
        req_data  = 32'h0000_00A5;
        req_valid = 4'b0001;
        expect_grant("t1", 0, 8'hA5);
        check("t1 busy", 32'(busy), 1);
        req_valid = '0;
        @(negedge clk);
        check("t1 ready/transmit 1 cycle", 32'({req_ready, uart_transmit}), 0);
        expect_done("t1", DONE_LAT - 1);
        @(negedge clk);
        check("t1 tx_done 1 cycle", 32'(tx_done), 0);

        // 2: all four held, round-robin 0,1,2,3,0 from reset
        do_reset();
        req_data  = 32'h4433_2211;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            expect_grant($sformatf("t2 g%0d", k), exp_ids[k], exp_bytes[k]);
            if (k == 4) req_valid = '0;
            expect_done($sformatf("t2 g%0d", k), DONE_LAT);
        end

        // 3: make rr_last=1, then 0 and 1 both valid -> 0 then 1
        req_data  = 32'h0000_5500;
        req_valid = 4'b0010;
        expect_grant("t3 setup", 1, 8'h55);
        req_valid = '0;
        expect_done("t3 setup", DONE_LAT);
        req_data  = 32'h0000_7766;
        req_valid = 4'b0011;
        expect_grant("t3 first", 0, 8'h66);
        expect_done("t3 first", DONE_LAT);
        expect_grant("t3 second", 1, 8'h77);
        req_valid = '0;
        expect_done("t3 second", DONE_LAT);

        // 4: uart never goes busy -> timeout START_TIMEOUT cycles after the ISSUE cycle
        uart_mode = 1;
        req_data  = 32'h0099_0000;
        req_valid = 4'b0100;
        expect_grant("t4", 2, 8'h99);
        req_valid = '0;
        wait_for(2, 60, n);
        check("t4 timeout latency", n, START_TIMEOUT + 1);
        check("t4 busy at timeout", 32'(busy), 0);
        check("t4 no tx_done", 32'(tx_done), 0);
        @(negedge clk);
        check("t4 pulse/busy after", 32'({timeout_err, busy}), 0);
        uart_mode = 0;

        // 5: uart busy while a request waits in IDLE
        uart_mode = 2;
        is_tx     = 1'b1;
        req_data  = 32'hC300_0000;
        req_valid = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t5 held %0d", k), 32'({uart_transmit, busy}), 0);
        end
        is_tx     = 1'b0;
        uart_mode = 0;
        expect_grant("t5", 3, 8'hC3);
        req_valid = '0;
        expect_done("t5", DONE_LAT);

        // 6: async reset during WAIT_DONE
        req_data  = 32'h005A_0000;
        req_valid = 4'b0100;
        expect_grant("t6", 2, 8'h5A);
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("t6 busy before rst", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check("t6 async tx_byte", 32'(uart_tx_byte), 0);
        check("t6 async grant_id", 32'(grant_id), 0);
        check("t6 async others", 32'({req_ready, uart_transmit, busy, tx_done, timeout_err}), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t6 silent %0d", k), 32'({tx_done, timeout_err}), 0);
        end
        req_data  = 32'hE400_00E1;
        req_valid = 4'b1001;
        expect_grant("t6 after rst", 0, 8'hE1);
        req_valid = '0;
        expect_done("t6 after rst", DONE_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
